// File: rtl/hdmi_rx_link_ctrl.sv
// HDMI receive link controller: HPD/receiver-enable sequencing, pixel-path reset and vsync-based lock.
// Optional macro HDMI_RX_DE_CHECK_EN: a vsync edge qualifies only after synchronized de was seen high.
module hdmi_rx_link_ctrl #(
  parameter int CLK_HZ           = 100_000_000,
  parameter int HPD_LOW_MS       = 500,
  parameter int SETTLE_MS        = 100,
  parameter int VSYNC_TIMEOUT_MS = 100,
  parameter int LOCK_FRAMES      = 4
) (
  input  logic       CLK,
  input  logic       reset_in,
  input  logic       vsync_in,
  input  logic       de_in,
  input  logic       force_retrain,
  output logic       hdmi_rx_hpa,
  output logic       hdmi_rx_txen,
  output logic       pix_rst,
  output logic       link_up,
  output logic [1:0] link_state,
  output logic [7:0] retry_count
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST    = PW'(TICK_DIV - 1);
  // Transitions fire on the tick that would bring ms_cnt up to the limit.
  localparam logic [15:0]   HPD_LAST     = 16'(HPD_LOW_MS - 1);
  localparam logic [15:0]   SETTLE_LAST  = 16'(SETTLE_MS - 1);
  localparam logic [15:0]   TIMEOUT_LAST = 16'(VSYNC_TIMEOUT_MS - 1);
  localparam logic [7:0]    LOCK_LAST    = 8'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    HPD_LOW = 2'd0,
    SETTLE  = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

`ifdef HDMI_RX_DE_CHECK_EN
  localparam int NSYNC = 2;
  logic [NSYNC-1:0] async_bits;
  assign async_bits = {de_in, vsync_in};
`else
  localparam int NSYNC = 1;
  logic [NSYNC-1:0] async_bits;
  logic             unused_de;
  assign async_bits = vsync_in;
  assign unused_de  = de_in;
`endif

  logic [NSYNC-1:0] sync_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NSYNC; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_bits[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_bits[gi] = sync_reg;
    end
  endgenerate

  logic          vsync_prev_reg;
  logic          vs_edge;
  logic [PW-1:0] presc_reg;
  logic          tick;
  state_t        state_reg, state_next;
  logic [15:0]   ms_cnt_reg, ms_cnt_next;
  logic [7:0]    frm_cnt_reg, frm_cnt_next;
  logic [7:0]    retry_reg, retry_next;
  logic          de_seen_reg, de_seen_next;
  logic          hpa_reg, pix_rst_reg, link_up_reg;
  logic [1:0]    link_state_reg;
  logic          de_ok, qual, state_change, retry_inc;

  assign vs_edge = sync_bits[0] & ~vsync_prev_reg;
  assign tick    = (presc_reg == TICK_LAST);

`ifdef HDMI_RX_DE_CHECK_EN
  assign de_ok = de_seen_reg | sync_bits[1];
`else
  assign de_ok = 1'b1;
`endif

  // Edges only matter once the pixel path is out of reset.
  assign qual = vs_edge & de_ok & ((state_reg == ACQUIRE) || (state_reg == LOCKED));

  always_comb begin
    state_next = state_reg;
    retry_inc  = 1'b0;
    case (state_reg)
      HPD_LOW: if (tick && ms_cnt_reg == HPD_LAST) state_next = SETTLE;
      SETTLE:  if (tick && ms_cnt_reg == SETTLE_LAST) state_next = ACQUIRE;
      ACQUIRE: begin
        if (qual) begin
          if (frm_cnt_reg == LOCK_LAST) state_next = LOCKED;
        end else if (tick && ms_cnt_reg == TIMEOUT_LAST) begin
          state_next = HPD_LOW;
          retry_inc  = 1'b1;
        end
      end
      LOCKED: begin
        if (!qual && tick && ms_cnt_reg == TIMEOUT_LAST) begin
          state_next = HPD_LOW;
          retry_inc  = 1'b1;
        end
      end
      default: state_next = HPD_LOW;
    endcase
    if (force_retrain) begin
      state_next = HPD_LOW;
      retry_inc  = 1'b0;
    end

    // A forced retrain restarts the HPD-low interval even if already there.
    state_change = force_retrain || (state_next != state_reg);

    ms_cnt_next = ms_cnt_reg;
    if (state_change || qual) ms_cnt_next = 16'd0;
    else if (tick)            ms_cnt_next = ms_cnt_reg + 16'd1;

    frm_cnt_next = frm_cnt_reg;
    if (state_change)                       frm_cnt_next = 8'd0;
    else if (qual && state_reg == ACQUIRE)  frm_cnt_next = frm_cnt_reg + 8'd1;

    retry_next = retry_reg;
    if (retry_inc && retry_reg != 8'hFF) retry_next = retry_reg + 8'd1;

    de_seen_next = de_seen_reg;
    if (state_change || vs_edge) de_seen_next = 1'b0;
    else if (NSYNC > 1)          de_seen_next = de_seen_reg | sync_bits[NSYNC-1];
  end

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      vsync_prev_reg <= 1'b0;
      presc_reg      <= '0;
      state_reg      <= HPD_LOW;
      ms_cnt_reg     <= 16'd0;
      frm_cnt_reg    <= 8'd0;
      retry_reg      <= 8'd0;
      de_seen_reg    <= 1'b0;
      hpa_reg        <= 1'b0;
      pix_rst_reg    <= 1'b1;
      link_up_reg    <= 1'b0;
      link_state_reg <= 2'd0;
    end else begin
      vsync_prev_reg <= sync_bits[0];
      presc_reg      <= tick ? '0 : presc_reg + 1'b1;
      state_reg      <= state_next;
      ms_cnt_reg     <= ms_cnt_next;
      frm_cnt_reg    <= frm_cnt_next;
      retry_reg      <= retry_next;
      de_seen_reg    <= de_seen_next;
      // Outputs are decoded from the next state so they track state_reg exactly.
      hpa_reg        <= (state_next != HPD_LOW);
      pix_rst_reg    <= (state_next == HPD_LOW) || (state_next == SETTLE);
      link_up_reg    <= (state_next == LOCKED);
      link_state_reg <= state_next;
    end
  end

  assign hdmi_rx_hpa  = hpa_reg;
  assign hdmi_rx_txen = hpa_reg;
  assign pix_rst      = pix_rst_reg;
  assign link_up      = link_up_reg;
  assign link_state   = link_state_reg;
  assign retry_count  = retry_reg;

endmodule

// File: doc/hdmi_rx_link_ctrl.md
# hdmi_rx_link_ctrl

HDMI receive link controller sitting beside `hdmi_in` and `edid_rom` in the board-clock domain. It sequences hot-plug assert (`hdmi_rx_hpa`) and receiver enable (`hdmi_rx_txen`), and holds the `hdmi_in` pixel path in reset while the source settles. It qualifies the incoming stream by counting vsync edges and declares `link_up`. On loss of video it drops HPD so the source re-reads EDID and retrains.

## Interface
- `CLK_HZ`, 100_000_000, board clock frequency; sets the 1 ms tick period (`CLK_HZ/1000` cycles).
- `HPD_LOW_MS`, 500, HPD deassert time in ms per retrain; range 1..65535.
- `SETTLE_MS`, 100, time with HPD high and `pix_rst` still held, in ms; range 1..65535.
- `VSYNC_TIMEOUT_MS`, 100, maximum gap between vsync edges, in ms; range 1..65535.
- `LOCK_FRAMES`, 4, qualifying vsync edges required to declare lock; range 1..255.
- `CLK  in  1`  board clock, 100 MHz.
- `reset_in  in  1`  asynchronous, active-high reset.
- `vsync_in  in  1`  vsync from `hdmi_in`, pixel domain; asynchronous to `CLK`.
- `de_in  in  1`  de from `hdmi_in`, pixel domain; asynchronous to `CLK`.
- `force_retrain  in  1`  CLK-synchronous one-cycle pulse requesting a retrain.
- `hdmi_rx_hpa  out  1`  hot-plug assert to the connector.
- `hdmi_rx_txen  out  1`  receiver buffer enable; always equal to `hdmi_rx_hpa`.
- `pix_rst  out  1`  reset to `hdmi_in.reset_in`, active-high.
- `link_up  out  1`  high only in LOCKED.
- `link_state  out  2`  current state encoding.
- `retry_count  out  8`  number of timeout-triggered retrains; saturates at 255.

## Operation
- Input sync: `vsync_in` and `de_in` each pass through a 2-flop synchronizer. A vsync edge is a rising edge of the synchronized vsync, found with one extra register. Vsync polarity is irrelevant because only the edge period is used.
- Prescaler: counts 0..`CLK_HZ/1000`-1 and emits a one-cycle `tick` at wrap. The prescaler free-runs and is never cleared except by reset.
- State counters:
  - `ms_cnt` (16 bit) advances on `tick` and clears on every state change.
  - `frm_cnt` (8 bit) counts qualifying vsync edges.
- States:
  - `HPD_LOW` (0): hpa=0, pix_rst=1. When `ms_cnt` reaches `HPD_LOW_MS`, go to `SETTLE`.
  - `SETTLE` (1): hpa=1, pix_rst=1. When `ms_cnt` reaches `SETTLE_MS`, go to `ACQUIRE` and clear `frm_cnt`.
  - `ACQUIRE` (2): hpa=1, pix_rst=0.
    - Each qualifying edge increments `frm_cnt` and clears `ms_cnt`.
    - When `frm_cnt` reaches `LOCK_FRAMES`, go to `LOCKED`.
    - When `ms_cnt` reaches `VSYNC_TIMEOUT_MS`, go to `HPD_LOW` and increment `retry_count`.
  - `LOCKED` (3): hpa=1, pix_rst=0, link_up=1.
    - Each qualifying edge clears `ms_cnt`.
    - When `ms_cnt` reaches `VSYNC_TIMEOUT_MS`, go to `HPD_LOW` and increment `retry_count`.
- `force_retrain`: from any state, the next state is `HPD_LOW`. `retry_count` is not incremented.
- Priority order, highest first:
  1. `reset_in`
  2. `force_retrain`
  3. qualifying edge
  4. timeout
- Boundary cases:
  - An edge arriving in the same cycle as timeout expiry wins: `ms_cnt` clears and there is no retrain.
  - Vsync edges seen in `HPD_LOW` or `SETTLE` are ignored.
  - `retry_count` holds at 255.
  - Asserting `reset_in` mid-operation forces `HPD_LOW` immediately (asynchronously); all counters clear.

## Timing
- Reset values:
  - `hdmi_rx_hpa`=0, `hdmi_rx_txen`=0, `pix_rst`=1, `link_up`=0, `link_state`=0, `retry_count`=0.
  - Internal counters are all 0.
- All outputs are registered and decoded from the state register. Outputs change in the cycle after the transition condition is evaluated true.
- Vsync edge detection latency: 3 CLK cycles from the `vsync_in` rise to the edge being visible to the FSM.
- Timeouts are tick-quantized: actual duration is between (N-1) ms + 1 cycle and N ms.
- `force_retrain` drives `hdmi_rx_hpa` to 0 one cycle after the pulse.

## Configuration
- `HDMI_RX_DE_CHECK_EN` defined:
  - A vsync edge qualifies only if synchronized `de` was sampled high at least once since the previous vsync edge, or since entry to `ACQUIRE`.
  - The de-seen flag clears on every vsync edge and on every state change.
- `HDMI_RX_DE_CHECK_EN` undefined:
  - Every vsync edge qualifies.
  - `de_in` is unused; the port remains present.

## Test plan
Common bench parameters: `CLK_HZ`=10000 (tick every 10 cycles), `HPD_LOW_MS`=5, `SETTLE_MS`=2, `VSYNC_TIMEOUT_MS`=4, `LOCK_FRAMES`=3.

- **Reset and bring-up:** release reset with no vsync -> hpa=0 for 50 cycles, then hpa=1 with pix_rst=1 for 20 cycles, then pix_rst=0 in `ACQUIRE`; after 40 more cycles, state returns to `HPD_LOW` and `retry_count`=1.
- **Lock acquisition:** in `ACQUIRE`, drive vsync pulses every 25 cycles -> `link_up`=1 one cycle after the 3rd edge is detected; `retry_count` unchanged.
- **Loss of signal:** while `LOCKED`, stop vsync -> `link_up` falls and hpa=0 within 40 cycles of the last edge; `retry_count` increments by 1.
- **Edge versus timeout collision:** place a vsync edge in exactly the cycle `ms_cnt` reaches 4 -> stays `LOCKED`, `ms_cnt`=0.
- **Forced retrain and async reset:**
  - Pulse `force_retrain` in `LOCKED` -> hpa=0 next cycle, `retry_count` unchanged.
  - Assert `reset_in` mid-`SETTLE` -> all outputs at reset values with no clock edge.
- **DE check (with `HDMI_RX_DE_CHECK_EN` defined):**
  - Vsync pulses with `de_in`=0 -> never locks; timeouts keep occurring because unqualified edges do not refresh `ms_cnt`.
  - Enable `de` pulses -> locks after 3 frames.
  - With the macro undefined, the same de-less stimulus locks after 3 frames.
